// File: rtl/bcd_keypad_entry_ctrl.sv
// bcd_keypad_entry_ctrl
// Synchronizes and debounces a 10-line one-hot keypad, encodes each accepted
// press to BCD, packs up to DIGITS digits and presents the entry on a
// valid/ready handshake when enter is requested.
// Optional feature macro: BCD_KEY_ERR_EN (reject multi-key presses, pulse key_err).
module bcd_keypad_entry_ctrl #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DEB_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            key,
    input  logic                  enter_in,
    input  logic                  clear_in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [2:0]            out_count,
    output logic [2:0]            digit_cnt,
    output logic                  overflow,
    output logic                  key_err
);

    localparam int unsigned W   = 4 * DIGITS;
    localparam int unsigned DCW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        PRESENT
    } state_t;

    state_t         state_q, state_d;
    logic [9:0]     sync1_q, ks_q;
    logic [9:0]     kv_q, kv_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [W-1:0]   buf_q, buf_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic [3:0]     enc;
    logic           accept;
    logic           hold_done;
    logic           reject;

    // Two-flop synchronizer for the asynchronous key lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            ks_q    <= '0;
        end else begin
            sync1_q <= key;
            ks_q    <= sync1_q;
        end
    end

    // Highest set index of the debounced key vector wins
    always_comb begin
        enc = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (kv_q[i]) enc = 4'(i);
        end
    end

    // The latching sample counts as the first match, so the threshold is DEB_CYCLES-2
    assign accept    = (state_q == DEBOUNCE) && (ks_q == kv_q) &&
                       (dcnt_q == DCW'(DEB_CYCLES - 2));
    assign hold_done = (state_q == HOLD) && (ks_q == '0) &&
                       (dcnt_q == DCW'(DEB_CYCLES - 1));

`ifdef BCD_KEY_ERR_EN
    assign reject = |(kv_q & (kv_q - 10'd1));
`else
    assign reject = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; clear_in overrides every transition
    always_comb begin
        state_d = state_q;
        if (clear_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ks_q != '0)                          state_d = DEBOUNCE;
                    else if (enter_in && (cnt_q != 3'd0))    state_d = PRESENT;
                end
                DEBOUNCE: begin
                    if (ks_q == '0)  state_d = IDLE;
                    else if (accept) state_d = HOLD;
                end
                HOLD: begin
                    if (hold_done) state_d = IDLE;
                end
                PRESENT: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: presentation outputs are driven only in PRESENT
    always_comb begin
        out_valid = (state_q == PRESENT);
        out_bcd   = out_valid ? buf_q : '0;
        out_count = out_valid ? cnt_q : '0;
    end

    assign digit_cnt = cnt_q;
    assign overflow  = ovf_q;

    // Datapath next values: latch/debounce counting, digit packing, handshake clear
    always_comb begin
        kv_d   = kv_q;
        dcnt_d = dcnt_q;
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clear_in) begin
            buf_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ks_q != '0) begin
                        kv_d   = ks_q;
                        dcnt_d = '0;
                    end
                end
                DEBOUNCE: begin
                    if (ks_q != '0 && ks_q != kv_q) begin
                        kv_d   = ks_q;
                        dcnt_d = '0;
                    end else if (accept) begin
                        dcnt_d = '0;
                        if (!reject) begin
                            if (cnt_q < 3'(DIGITS)) begin
                                buf_d = (buf_q << 4) | W'(enc);
                                cnt_d = cnt_q + 3'd1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end else if (ks_q == kv_q) begin
                        dcnt_d = dcnt_q + DCW'(1);
                    end
                end
                HOLD: begin
                    if (ks_q != '0)      dcnt_d = '0;
                    else if (!hold_done) dcnt_d = dcnt_q + DCW'(1);
                end
                PRESENT: begin
                    if (out_ready) begin
                        buf_d = '0;
                        cnt_d = '0;
                        ovf_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kv_q   <= '0;
            dcnt_q <= '0;
            buf_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            kv_q   <= kv_d;
            dcnt_q <= dcnt_d;
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef BCD_KEY_ERR_EN
    logic kerr_q;

    // One-cycle error pulse following a rejected multi-key accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) kerr_q <= 1'b0;
        else     kerr_q <= !clear_in && accept && reject;
    end

    assign key_err = kerr_q;
`else
    assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_keypad_entry_ctrl.sv
// Self-checking bench for bcd_keypad_entry_ctrl: directed scenarios followed by
// randomized presses/enters/clears checked against a queue-based digit model.
module tb_bcd_keypad_entry_ctrl;

    localparam int DIGITS = 4;
    localparam int DEB    = 8;
    localparam int ACCEPT_TICKS = DEB + 2;
`ifdef BCD_KEY_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [9:0]          key = '0;
    logic                enter_in = 1'b0;
    logic                clear_in = 1'b0;
    logic                out_ready = 1'b0;
    logic                out_valid;
    logic [4*DIGITS-1:0] out_bcd;
    logic [2:0]          out_count;
    logic [2:0]          digit_cnt;
    logic                overflow;
    logic                key_err;

    bcd_keypad_entry_ctrl #(.DIGITS(DIGITS), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .enter_in  (enter_in),
        .clear_in  (clear_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_count (out_count),
        .digit_cnt (digit_cnt),
        .overflow  (overflow),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: digits in typing order plus sticky overflow
    int unsigned mq[$];
    bit          m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word();
        logic [31:0] w = 0;
        foreach (mq[i]) w = w * 16 + mq[i];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
    endtask

    // Hold pattern k for 'hold' cycles then release for 'rel' cycles
    task automatic press(input logic [9:0] k, input int hold, input int rel);
        int  old_cnt = mq.size();
        bit  acc     = (hold >= ACCEPT_TICKS);
        int  hi      = 0;
        bit  multi   = ($countones(k) > 1);
        int  exp_err = 0;
        int  errs    = 0;
        for (int i = 0; i < 10; i++) if (k[i]) hi = i;
        if (acc) begin
            if (ERR_EN && multi)          exp_err = 1;
            else if (mq.size() < DIGITS)  mq.push_back(hi);
            else                          m_ovf = 1'b1;
        end
        key = k;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (key_err) errs++;
            if (acc && i == ACCEPT_TICKS - 1) check("cnt_before_accept", 32'(digit_cnt), 32'(old_cnt));
            if (acc && i == ACCEPT_TICKS) begin
                check("cnt_at_accept", 32'(digit_cnt), 32'(mq.size()));
                check("ovf_at_accept", 32'(overflow), 32'(m_ovf));
            end
        end
        key = '0;
        for (int i = 0; i < rel; i++) begin
            tick();
            if (key_err) errs++;
        end
        check("cnt_after_release", 32'(digit_cnt), 32'(mq.size()));
        check("ovf_after_release", 32'(overflow), 32'(m_ovf));
        check("key_err_pulses", 32'(errs), 32'(exp_err));
        check("valid_idle", 32'(out_valid), 32'd0);
    endtask

    // Request presentation, stall bp cycles, then complete the handshake
    task automatic do_enter(input int bp);
        enter_in  = 1'b1;
        out_ready = (bp == 0);
        tick();
        enter_in = 1'b0;
        if (mq.size() == 0) begin
            check("enter_empty_valid", 32'(out_valid), 32'd0);
            tick();
            check("enter_empty_valid2", 32'(out_valid), 32'd0);
            out_ready = 1'b0;
            return;
        end
        check("present_valid", 32'(out_valid), 32'd1);
        check("present_bcd", 32'(out_bcd), exp_word());
        check("present_count", 32'(out_count), 32'(mq.size()));
        for (int i = 0; i < bp; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_bcd", 32'(out_bcd), exp_word());
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        model_clear();
        check("post_xfer_valid", 32'(out_valid), 32'd0);
        check("post_xfer_bcd", 32'(out_bcd), 32'd0);
        check("post_xfer_cnt", 32'(digit_cnt), 32'd0);
        check("post_xfer_ovf", 32'(overflow), 32'd0);
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        model_clear();
        check("clear_cnt", 32'(digit_cnt), 32'd0);
        check("clear_ovf", 32'(overflow), 32'd0);
        check("clear_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_bcd"},   32'(out_bcd),   32'd0);
        check({tag, "_count"}, 32'(out_count), 32'd0);
        check({tag, "_cnt"},   32'(digit_cnt), 32'd0);
        check({tag, "_ovf"},   32'(overflow),  32'd0);
        check({tag, "_err"},   32'(key_err),   32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        check_all_zero("reset");
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic entry 3,7
        press(10'(1 << 3), 20, 20);
        press(10'(1 << 7), 20, 20);
        do_enter(0);

        // Glitch rejection
        press(10'(1 << 5), 4, 14);

        // Overflow with five digits
        for (int d = 1; d <= 5; d++) press(10'(1 << d), 15, 15);
        do_enter(2);

        // Backpressure then clear aborts presentation
        press(10'(1 << 9), 20, 20);
        enter_in = 1'b1;
        tick();
        enter_in = 1'b0;
        check("bp_valid0", 32'(out_valid), 32'd1);
        check("bp_bcd0", 32'(out_bcd), exp_word());
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_bcd", 32'(out_bcd), exp_word());
        end
        clear_in  = 1'b1;
        out_ready = 1'b1;
        tick();
        clear_in  = 1'b0;
        out_ready = 1'b0;
        model_clear();
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_cnt", 32'(digit_cnt), 32'd0);
        tick();
        check("abort_valid2", 32'(out_valid), 32'd0);

        // Multi-key press
        press(10'b0000100100, 20, 20);
        do_enter(0);

        // Reset mid-debounce
        press(10'(1 << 1), 15, 15);
        key = 10'(1 << 4);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        key = '0;
        repeat (2) tick();
        rst = 1'b0;
        model_clear();
        repeat (12) tick();
        check("rst_no_digit", 32'(digit_cnt), 32'd0);
        press(10'(1 << 4), 20, 20);
        do_enter(1);

        // Randomized operations
        for (int it = 0; it < 40; it++) begin
            int unsigned op = $urandom_range(0, 99);
            if (op < 60) begin
                press(10'(1 << $urandom_range(0, 9)), $urandom_range(12, 20), $urandom_range(12, 20));
            end else if (op < 68) begin
                press(10'((1 << $urandom_range(0, 9)) | (1 << $urandom_range(0, 9))),
                      $urandom_range(12, 20), $urandom_range(12, 20));
            end else if (op < 76) begin
                press(10'(1 << $urandom_range(0, 9)), $urandom_range(1, 5), 14);
            end else if (op < 94) begin
                do_enter(int'($urandom_range(0, 5)));
            end else begin
                do_clear();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_keypad_entry_ctrl.md
Name: bcd_keypad_entry_ctrl

Overview:
- Sequences multi-digit decimal entry from a 10-line one-hot keypad: bit i of key = digit i.
- Synchronizes and debounces the key lines, then encodes each accepted press to 4-bit BCD (same decimal-to-BCD function as the team's encoder).
- Packs digits into a DIGITS-wide BCD word and presents it on a valid/ready handshake when enter is pressed.
- Sits between the raw keypad pins and downstream numeric consumers.

Parameters:
- DIGITS, 4, max digits held; range 1..7.
- DEB_CYCLES, 8, consecutive identical synchronized samples required to accept a press or a release; must be ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- key  in  10  raw keypad lines, asynchronous, active-high.
- enter_in  in  1  request to present the current entry; sampled each cycle.
- clear_in  in  1  discard the current entry; sampled each cycle.
- out_ready  in  1  downstream accepts out_bcd.
- out_valid  out  1  out_bcd and out_count are valid.
- out_bcd  out  4*DIGITS  packed BCD; first digit typed is the most significant of the entered digits.
- out_count  out  3  number of digits in out_bcd.
- digit_cnt  out  3  live count of digits entered.
- overflow  out  1  sticky; a digit was dropped because the entry was full.
- key_err  out  1  one-cycle multi-key error pulse; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset: all outputs 0; internal buffer and counters cleared; state IDLE. Reset may occur in any state with no pending effects.
- Synchronizer: key passes through a 2-flop synchronizer; all logic uses the synchronized vector ks.
- Encoding: highest set index wins (e.g. 10'b0000100100 encodes 5).
- IDLE:
  - ks ≠ 0: latch ks into kv, zero the debounce counter, go to DEBOUNCE.
  - enter_in=1 and digit_cnt>0: go to PRESENT.
  - enter_in=1 and digit_cnt=0: ignored.
- DEBOUNCE:
  - ks == kv: counter increments.
  - ks ≠ kv and ks ≠ 0: re-latch kv and restart the count.
  - ks = 0: back to IDLE with no digit.
  - When DEB_CYCLES matching samples are reached: accept the digit and go to HOLD.
  - Accept when digit_cnt < DIGITS: buffer shifts left 4 bits, new digit enters the low nibble, digit_cnt+1.
  - Accept when digit_cnt = DIGITS: digit dropped, overflow set.
  - Timing: with DEB_CYCLES=8, digit_cnt updates exactly 10 cycles after a clean raw press edge.
- HOLD:
  - Waits for ks = 0 for DEB_CYCLES consecutive cycles, then goes to IDLE. Any nonzero sample restarts this count.
  - enter_in is ignored.
- PRESENT:
  - out_valid=1, out_bcd=buffer, out_count=digit_cnt. These are held stable until out_valid & out_ready.
  - On that cycle: buffer, digit_cnt and overflow are cleared, then IDLE. out_valid falls the following cycle.
  - Keys are ignored (not queued).
  - out_bcd and out_count read 0 outside PRESENT.
- clear_in: highest priority below rst.
  - In any state, at the next edge: buffer, digit_cnt, overflow and out_valid are cleared, state goes to IDLE.
  - In PRESENT this aborts the presentation; no transfer occurs even if out_ready=1 in the same cycle.
- enter_in and a key accept in the same cycle: the accept completes first; enter is ignored in DEBOUNCE/HOLD.

Optional Feature:
- Macro: BCD_KEY_ERR_EN.
- Defined:
  - When the debounced kv has more than one bit set, the digit is rejected and key_err pulses high for exactly the accept cycle.
  - digit_cnt and the buffer are unchanged; the FSM still proceeds to HOLD.
- Undefined: highest-index priority encoding applies; key_err is constant 0.

Test Plan:
- Reset: assert rst mid-DEBOUNCE with key[4] held -> all outputs 0 immediately; after release, no digit is counted until a fresh 10-cycle press.
- Basic entry: press key[3] 20 cycles, release 20; press key[7] likewise; pulse enter_in with out_ready=1 -> out_valid=1 for one cycle, out_bcd=16'h0037, out_count=2, then digit_cnt=0.
- Glitch rejection: key[5] high 4 cycles then low -> digit_cnt stays 0, no state change beyond IDLE.
- Overflow: enter digits 1,2,3,4,5 (DIGITS=4) -> digit_cnt=4, overflow=1; enter -> out_bcd=16'h1234, out_count=4; overflow clears after the handshake.
- Backpressure and clear: enter 9, enter_in, out_ready=0 for 6 cycles -> out_valid stays 1 and out_bcd stays 16'h0009; assert clear_in -> out_valid=0 the next cycle and no transfer occurs.
- Multi-key: key=10'b0000100100 held 20 cycles -> without macro digit 5 is accepted; with BCD_KEY_ERR_EN, key_err pulses one cycle and digit_cnt is unchanged.
